vx_fpu_csr_sched: RTL and testbench
===================================

Name: vx_fpu_csr_sched

Overview:
- Shares the single FPU-to-CSR port (fflags write, frm read) between NUM_REQS FPU requesters.
- Accumulates sticky fflags per warp by OR-merging and drains at most one CSR write per cycle, round-robin over warps.
- Arbitrates frm read requests round-robin and returns a registered response.
- Sits between the FPU lanes/units and the CSR unit's fflags/frm port.

Parameters:
- NUM_REQS, 4, number of FPU requesters.
- NUM_WARPS, 4, number of warps; NW_BITS = max(1, clog2(NUM_WARPS)).
- FFLAGS_BITS, 5, fflags width (NV, DZ, OF, UF, NX).
- FRM_BITS, 3, rounding-mode width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_fflags_valid  in  NUM_REQS  per-requester fflags update strobe. No backpressure; always accepted.
- req_fflags_wid  in  NUM_REQS*NW_BITS  warp id per update.
- req_fflags  in  NUM_REQS*FFLAGS_BITS  flags per update.
- req_frm_valid  in  NUM_REQS  frm read request.
- req_frm_wid  in  NUM_REQS*NW_BITS  warp id of frm read.
- req_frm_ready  out  NUM_REQS  one-hot grant, combinational.
- rsp_frm_valid  out  NUM_REQS  one-hot response, registered.
- rsp_frm  out  FRM_BITS  rounding mode for the granted requester.
- csr_write_enable  out  1  fflags write to CSR.
- csr_write_wid  out  NW_BITS  warp id of write.
- csr_write_fflags  out  FFLAGS_BITS  flags to OR into the CSR fflags.
- csr_read_wid  out  NW_BITS  warp id presented to CSR frm read.
- csr_read_frm  in  FRM_BITS  combinational frm from CSR.
- pending_mask  out  NUM_WARPS  warps with undrained flags; the CSR stalls fflags/fcsr reads on its set bits.

Behaviour:
- Reset (reset==0 at a clk edge):
  - acc[], pend[], both RR pointers and all registered outputs clear to 0.
  - Contents pending at reset are discarded.
- Merge (combinational):
  - in_f[w] = OR of req_fflags[i] over all i where req_fflags_valid[i] and wid==w.
  - in_v[w] = (in_f[w] != 0). Updates with all-zero flags never set pend.
  - Any number of requesters may target the same warp in one cycle.
- Drain select:
  - d = first warp with pend[w]==1, scanning from wptr upward, mod NUM_WARPS. Uses registered pend only.
  - Next edge: csr_write_enable<=1, csr_write_wid<=d, csr_write_fflags<=acc[d], wptr<=(d+1) mod NUM_WARPS.
  - If no pend bit is set: csr_write_enable<=0, wid/fflags<=0, wptr unchanged.
- Accumulator update at each edge:
  - Drained warp d: acc[d]<=in_f[d], pend[d]<=in_v[d]. Same-cycle arrivals are never lost.
  - Every other warp w: acc[w]<=acc[w]|in_f[w], pend[w]<=pend[w]|in_v[w].
- Latency: update at cycle t → pend at t+1 → csr_write_enable at t+2.
- Throughput: one warp per cycle.
- Starvation bound: a pending warp is written within NUM_WARPS cycles.
- pending_mask = pend | in_v (combinational). Once a warp's write is on the csr_write_* outputs, its bit is clear unless new flags arrived.
- frm arbitration:
  - g = first i with req_frm_valid[i], scanning from rptr.
  - req_frm_ready = onehot(g); csr_read_wid = req_frm_wid[g].
  - With no requests: req_frm_ready=0, csr_read_wid=0, rptr unchanged.
  - On grant: rptr<=(g+1) mod NUM_REQS.
  - Next edge: rsp_frm_valid<=onehot(g), rsp_frm<=csr_read_frm. Otherwise rsp_frm_valid<=0 and rsp_frm holds.
  - One grant per cycle; a requester holds valid and wid stable until ready.
- Read and write paths are independent; both may be active in the same cycle.

Decomposition:
- Shared FPU types package: FFLAGS_BITS, FRM_BITS constants; fflags_t packed struct {NV,DZ,OF,UF,NX}.
- Sub-module vx_rr_arbiter (N, request vector, enable-advance; outputs one-hot grant and index).
  - Instanced twice: NUM_WARPS wide for drain, NUM_REQS wide for frm.

Test Plan:
- Single update: req0 valid, wid=2, fflags=5'b00001 at cycle t → csr_write_enable=1, wid=2, fflags=00001 at t+2; pending_mask[2]=1 at t and t+1, 0 at t+2.
- Merge: req0 (wid1, 10000) and req3 (wid1, 00100) in the same cycle → exactly one write, wid1, fflags=10100.
- Drain race: warp1 pending with 00001; in the drain-select cycle req2 sends wid1, 00010 → writes wid1/00001, then wid1/00010 one cycle later; nothing lost.
- Fairness: all four warps pending with distinct flags and continuous re-injection to warp0 → write order 0,1,2,3,0… from wptr=0; warp3 written within 4 cycles.
- Zero flags and reset: update fflags=0 → no pend, no write. Reset=0 while 3 warps are pending → all outputs 0 next cycle, no writes afterward.
- frm arbitration: req1 and req2 valid persistently (wid 1 and 2, CSR frm=wid+1) → grants alternate 1,2,1; rsp one cycle later with rsp_frm=2,3,2; never two ready bits high.

Source files
------------

// File: rtl/vx_fpu_csr_sched_pkg.sv
// Shared FPU/CSR types: flag and rounding-mode widths, the fflags layout and an index-width helper.
// Pure declarations: no latency and no flow control.
package vx_fpu_csr_sched_pkg;

  localparam int FFLAGS_BITS = 5;
  localparam int FRM_BITS    = 3;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic int nw_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant/index, scanning upward from a pointer.
// Pointer moves past the winner when en_i is high; requesters hold until granted.
module vx_rr_arbiter
  import vx_fpu_csr_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = nw_bits(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan from the farthest slot back toward ptr so the nearest request wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int pos;
      pos = int'(ptr_q) + k;
      if (pos >= N) pos = pos - N;
      if (req_i[pos]) begin
        grant_o      = '0;
        grant_o[pos] = 1'b1;
        idx_o        = IW'(pos);
        valid_o      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && valid_o) begin
      ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vx_fpu_csr_sched.sv
// Shares the FPU-to-CSR port: sticky per-warp fflags drained one write/cycle RR; frm reads RR-granted.
// Update->write is 2 cycles, frm grant->rsp 1 cycle; fflags updates are never backpressured.
module vx_fpu_csr_sched
  import vx_fpu_csr_sched_pkg::*;
#(
  parameter  int NUM_REQS    = 4,
  parameter  int NUM_WARPS   = 4,
  parameter  int FFLAGS_BITS = 5,
  parameter  int FRM_BITS    = 3,
  localparam int NW_BITS     = nw_bits(NUM_WARPS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_fflags_valid,
  input  logic [NUM_REQS*NW_BITS-1:0]     req_fflags_wid,
  input  logic [NUM_REQS*FFLAGS_BITS-1:0] req_fflags,
  input  logic [NUM_REQS-1:0]             req_frm_valid,
  input  logic [NUM_REQS*NW_BITS-1:0]     req_frm_wid,
  output logic [NUM_REQS-1:0]             req_frm_ready,
  output logic [NUM_REQS-1:0]             rsp_frm_valid,
  output logic [FRM_BITS-1:0]             rsp_frm,
  output logic                            csr_write_enable,
  output logic [NW_BITS-1:0]              csr_write_wid,
  output logic [FFLAGS_BITS-1:0]          csr_write_fflags,
  output logic [NW_BITS-1:0]              csr_read_wid,
  input  logic [FRM_BITS-1:0]             csr_read_frm,
  output logic [NUM_WARPS-1:0]            pending_mask
);

  localparam int RQ_BITS = nw_bits(NUM_REQS);

  logic [FFLAGS_BITS-1:0] acc_q [NUM_WARPS];
  logic [FFLAGS_BITS-1:0] acc_d [NUM_WARPS];
  logic [FFLAGS_BITS-1:0] in_f  [NUM_WARPS];
  logic [NUM_WARPS-1:0]   pend_q, pend_d, in_v;

  logic [NUM_WARPS-1:0]   drain_gnt;
  logic [NW_BITS-1:0]     drain_idx;
  logic                   drain_vld;

  logic                   wr_en_q, wr_en_d;
  logic [NW_BITS-1:0]     wr_wid_q, wr_wid_d;
  logic [FFLAGS_BITS-1:0] wr_fl_q, wr_fl_d;

  logic [NUM_REQS-1:0]    frm_gnt;
  logic [RQ_BITS-1:0]     frm_idx;
  logic                   frm_vld;
  logic [NUM_REQS-1:0]    rsp_vld_q, rsp_vld_d;
  logic [FRM_BITS-1:0]    rsp_frm_q, rsp_frm_d;

  // Several requesters may hit the same warp in one cycle; their flags OR together.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      in_f[w] = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (req_fflags_valid[i] && (req_fflags_wid[i*NW_BITS +: NW_BITS] == NW_BITS'(w))) begin
          in_f[w] = in_f[w] | req_fflags[i*FFLAGS_BITS +: FFLAGS_BITS];
        end
      end
      in_v[w] = |in_f[w];
    end
  end

  vx_rr_arbiter #(.N(NUM_WARPS)) u_drain_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (pend_q),
    .en_i    (1'b1),
    .grant_o (drain_gnt),
    .idx_o   (drain_idx),
    .valid_o (drain_vld)
  );

  // The drained warp restarts from this cycle's arrivals so nothing landing mid-drain is lost.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (drain_gnt[w]) begin
        acc_d[w]  = in_f[w];
        pend_d[w] = in_v[w];
      end else begin
        acc_d[w]  = acc_q[w] | in_f[w];
        pend_d[w] = pend_q[w] | in_v[w];
      end
    end
    wr_en_d  = drain_vld;
    wr_wid_d = drain_vld ? drain_idx : '0;
    wr_fl_d  = drain_vld ? acc_q[drain_idx] : '0;
  end

  vx_rr_arbiter #(.N(NUM_REQS)) u_frm_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_frm_valid),
    .en_i    (1'b1),
    .grant_o (frm_gnt),
    .idx_o   (frm_idx),
    .valid_o (frm_vld)
  );

  always_comb begin
    rsp_vld_d = frm_gnt;
    rsp_frm_d = frm_vld ? csr_read_frm : rsp_frm_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) acc_q[w] <= '0;
      pend_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_wid_q  <= '0;
      wr_fl_q   <= '0;
      rsp_vld_q <= '0;
      rsp_frm_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) acc_q[w] <= acc_d[w];
      pend_q    <= pend_d;
      wr_en_q   <= wr_en_d;
      wr_wid_q  <= wr_wid_d;
      wr_fl_q   <= wr_fl_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_frm_q <= rsp_frm_d;
    end
  end

  assign pending_mask     = pend_q | in_v;
  assign csr_write_enable = wr_en_q;
  assign csr_write_wid    = wr_wid_q;
  assign csr_write_fflags = wr_fl_q;
  assign req_frm_ready    = frm_gnt;
  assign csr_read_wid     = frm_vld ? req_frm_wid[frm_idx*NW_BITS +: NW_BITS] : '0;
  assign rsp_frm_valid    = rsp_vld_q;
  assign rsp_frm          = rsp_frm_q;

endmodule

// File: tb/tb_vx_fpu_csr_sched.sv
// Directed bench for vx_fpu_csr_sched: expected CSR writes and frm responses queue up at issue
// and are popped by independent monitors whenever the DUT presents them.
module tb_vx_fpu_csr_sched;
  import vx_fpu_csr_sched_pkg::*;

  localparam int NR  = 4;
  localparam int NW  = 4;
  localparam int NWB = 2;
  localparam int FB  = FFLAGS_BITS;
  localparam int RB  = FRM_BITS;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req_fflags_valid;
  logic [NR*NWB-1:0] req_fflags_wid;
  logic [NR*FB-1:0]  req_fflags;
  logic [NR-1:0]   req_frm_valid;
  logic [NR*NWB-1:0] req_frm_wid;
  logic [NR-1:0]   req_frm_ready;
  logic [NR-1:0]   rsp_frm_valid;
  logic [RB-1:0]   rsp_frm;
  logic            csr_write_enable;
  logic [NWB-1:0]  csr_write_wid;
  logic [FB-1:0]   csr_write_fflags;
  logic [NWB-1:0]  csr_read_wid;
  logic [RB-1:0]   csr_read_frm;
  logic [NW-1:0]   pending_mask;

  always #5 clk = ~clk;

  // CSR model: frm of warp w is w+1.
  assign csr_read_frm = RB'(csr_read_wid) + RB'(1);

  vx_fpu_csr_sched #(
    .NUM_REQS(NR), .NUM_WARPS(NW), .FFLAGS_BITS(FB), .FRM_BITS(RB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_fflags_valid (req_fflags_valid),
    .req_fflags_wid   (req_fflags_wid),
    .req_fflags       (req_fflags),
    .req_frm_valid    (req_frm_valid),
    .req_frm_wid      (req_frm_wid),
    .req_frm_ready    (req_frm_ready),
    .rsp_frm_valid    (rsp_frm_valid),
    .rsp_frm          (rsp_frm),
    .csr_write_enable (csr_write_enable),
    .csr_write_wid    (csr_write_wid),
    .csr_write_fflags (csr_write_fflags),
    .csr_read_wid     (csr_read_wid),
    .csr_read_frm     (csr_read_frm),
    .pending_mask     (pending_mask)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { int c; int wid; int fl; } wexp_t;
  typedef struct { int c; int v;   int frm; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_w(input int c, input int wid, input int fl);
    wexp_t e;
    e.c = c; e.wid = wid; e.fl = fl;
    wq.push_back(e);
  endtask

  task automatic push_r(input int c, input int v, input int frm);
    rexp_t e;
    e.c = c; e.v = v; e.frm = frm;
    rq.push_back(e);
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (csr_write_enable) begin
      if (wq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got wid %0d fflags 0x%0h, wanted no write (cycle %0d)",
                 csr_write_wid, csr_write_fflags, cyc);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        chk("write_cycle",  cyc, e.c);
        chk("write_wid",    int'(csr_write_wid), e.wid);
        chk("write_fflags", int'(csr_write_fflags), e.fl);
      end
    end
  end

  // frm response monitor
  always @(negedge clk) begin
    if (rsp_frm_valid != '0) begin
      if (rq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rsp: got valid 0x%0h frm %0d, wanted none (cycle %0d)",
                 rsp_frm_valid, rsp_frm, cyc);
      end else begin
        rexp_t e;
        e = rq.pop_front();
        chk("rsp_cycle", cyc, e.c);
        chk("rsp_valid", int'(rsp_frm_valid), e.v);
        chk("rsp_frm",   int'(rsp_frm), e.frm);
      end
    end
  end

  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_mid();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc_begin();
  endtask

  task automatic clr();
    req_fflags_valid = '0;
    req_fflags_wid   = '0;
    req_fflags       = '0;
    req_frm_valid    = '0;
    req_frm_wid      = '0;
  endtask

  task automatic upd(input int i, input int wid, input int fl);
    req_fflags_valid[i]         = 1'b1;
    req_fflags_wid[i*NWB +: NWB] = NWB'(wid);
    req_fflags[i*FB +: FB]       = FB'(fl);
  endtask

  initial begin
    int t;
    fflags_t nv_only;
    nv_only = '{nv: 1'b1, default: 1'b0};
    clr();

    // Reset state
    reset = 1'b0;
    idle(3);
    cyc_mid();
    chk("rst_write_en",  int'(csr_write_enable), 0);
    chk("rst_pending",   int'(pending_mask), 0);
    chk("rst_rsp_valid", int'(rsp_frm_valid), 0);
    chk("rst_rsp_frm",   int'(rsp_frm), 0);
    chk("rst_ready",     int'(req_frm_ready), 0);
    cyc_begin();
    reset = 1'b1;
    idle(2);

    // Fairness from wptr=0 with warp0 re-injected
    cyc_begin();
    upd(0, 0, 5'b00001); upd(1, 1, 5'b00010); upd(2, 2, 5'b00100); upd(3, 3, 5'b01000);
    t = cyc;
    push_w(t + 2, 0, 5'b00001);
    push_w(t + 3, 1, 5'b00010);
    push_w(t + 4, 2, 5'b00100);
    push_w(t + 5, 3, 5'b01000);
    push_w(t + 6, 0, int'(nv_only));
    cyc_mid();
    chk("fair_pending", int'(pending_mask), 4'b1111);
    for (int k = 0; k < 4; k++) begin
      cyc_begin();
      clr();
      upd(0, 0, int'(nv_only));
    end
    cyc_begin();
    clr();
    idle(3);

    // Single update to warp 2
    cyc_begin();
    upd(0, 2, 5'b00001);
    t = cyc;
    push_w(t + 2, 2, 5'b00001);
    cyc_mid();
    chk("single_pm_t0", int'(pending_mask), 4'b0100);
    cyc_begin();
    clr();
    cyc_mid();
    chk("single_pm_t1", int'(pending_mask), 4'b0100);
    cyc_begin();
    cyc_mid();
    chk("single_pm_t2", int'(pending_mask), 4'b0000);
    idle(2);

    // Merge of two requesters on warp 1
    cyc_begin();
    upd(0, 1, 5'b10000); upd(3, 1, 5'b00100);
    t = cyc;
    push_w(t + 2, 1, 5'b10100);
    cyc_begin();
    clr();
    idle(3);

    // Drain race on warp 1
    cyc_begin();
    upd(0, 1, 5'b00001);
    t = cyc;
    push_w(t + 2, 1, 5'b00001);
    push_w(t + 3, 1, 5'b00010);
    cyc_begin();
    clr();
    upd(2, 1, 5'b00010);
    cyc_mid();
    chk("race_pending", int'(pending_mask), 4'b0010);
    cyc_begin();
    clr();
    idle(4);

    // All-zero flags never set pend
    cyc_begin();
    upd(1, 3, 0);
    cyc_mid();
    chk("zero_pm_t0", int'(pending_mask), 0);
    cyc_begin();
    clr();
    cyc_mid();
    chk("zero_pm_t1", int'(pending_mask), 0);
    idle(3);

    // Reset while three warps are pending
    cyc_begin();
    upd(0, 0, 5'b00001); upd(1, 1, 5'b00010); upd(2, 2, 5'b00100);
    cyc_begin();
    clr();
    reset = 1'b0;
    cyc_mid();
    chk("prerst_pending", int'(pending_mask), 4'b0111);
    cyc_begin();
    cyc_mid();
    chk("postrst_write_en", int'(csr_write_enable), 0);
    chk("postrst_wid",      int'(csr_write_wid), 0);
    chk("postrst_fflags",   int'(csr_write_fflags), 0);
    chk("postrst_pending",  int'(pending_mask), 0);
    cyc_begin();
    reset = 1'b1;
    idle(6);

    // frm arbitration: req1 (wid1) and req2 (wid2) persistently valid
    for (int k = 0; k < 4; k++) begin
      int g;
      cyc_begin();
      req_frm_valid              = 4'b0110;
      req_frm_wid[1*NWB +: NWB]  = NWB'(1);
      req_frm_wid[2*NWB +: NWB]  = NWB'(2);
      g = (k % 2 == 0) ? 1 : 2;
      push_r(cyc + 1, 1 << g, g + 1);
      cyc_mid();
      chk("frm_ready",        int'(req_frm_ready), 1 << g);
      chk("frm_ready_onehot", $countones(req_frm_ready), 1);
      chk("frm_read_wid",     int'(csr_read_wid), g);
    end
    cyc_begin();
    clr();
    cyc_mid();
    chk("frm_idle_ready", int'(req_frm_ready), 0);
    chk("frm_idle_wid",   int'(csr_read_wid), 0);
    idle(3);
    cyc_mid();
    chk("frm_rsp_hold", int'(rsp_frm), 3);

    chk("write_queue_drained", wq.size(), 0);
    chk("rsp_queue_drained",   rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
